// File: rtl/i2s_dac_bridge.sv
// rtl/i2s_dac_bridge.sv - I2S stereo receiver feeding a dual serial DAC over SPI
module i2s_dac_bridge #(
  parameter int               SAMPLE_W    = 24,
  parameter int               DAC_W       = 16,
  parameter int               CMD_W       = 8,
  parameter logic [CMD_W-1:0] ADDR_L      = 8'h08,
  parameter logic [CMD_W-1:0] ADDR_R      = 8'h09,
  parameter int               DITHER_EN   = 1,
  parameter int               DITHER_BITS = 4,
  parameter int               SCLK_DIV    = 2,
  parameter int               SYNC_GAP    = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic bck_i,
  input  logic lrck_i,
  input  logic data_i,
  output logic sclk_o,
  output logic sync_n_o,
  output logic sdo_o,
  output logic sample_valid_o,
  output logic overrun_o,
  output logic frame_err_o,
  output logic busy_o
);

  localparam int CNT_W  = $clog2(SAMPLE_W + 1);
  localparam int N_BITS = CMD_W + DAC_W;
  localparam int BIT_W  = $clog2(N_BITS);
  localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int GAP_W  = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
  localparam logic [DAC_W-1:0] MID   = {1'b1, {(DAC_W-1){1'b0}}};
  localparam logic [DAC_W-1:0] S_MAX = {1'b0, {(DAC_W-1){1'b1}}};
  localparam logic [DAC_W-1:0] S_MIN = {1'b1, {(DAC_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} tx_state_t;

  logic [1:0]       bck_sy, lrck_sy, data_sy;
  logic             bck_d, bck_rise;
  logic             lr_init, lrck_q, in_frame, cap_stb, cap_ch;
  logic [CNT_W-1:0] bit_cnt;
  logic [DAC_W-1:0] shreg;
  logic [15:0]      lfsr, lfsr_nx;
  logic [DITHER_BITS:0] d_new, d1;
  logic [DAC_W-1:0] s1, sat, code;
  logic [DAC_W:0]   sum;
  logic             st1, ch1;
  tx_state_t        state;
  logic [N_BITS-1:0] tx_sh;
  logic [DIV_W-1:0] div;
  logic [BIT_W-1:0] bitc;
  logic [GAP_W-1:0] gapc;
  logic [DAC_W-1:0] pend_l, pend_r;
  logic             vld_l, vld_r, ld_l, ld_r;

  assign bck_rise = bck_sy[1] & ~bck_d;

  // two-flop synchronizers on the asynchronous I2S pins plus bck edge history
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bck_sy  <= '0;
      lrck_sy <= '0;
      data_sy <= '0;
      bck_d   <= 1'b0;
    end else begin
      bck_sy  <= {bck_sy[0], bck_i};
      lrck_sy <= {lrck_sy[0], lrck_i};
      data_sy <= {data_sy[0], data_i};
      bck_d   <= bck_sy[1];
    end
  end

  // I2S framing: the first rise only learns the lrck level, a level change opens a frame
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lr_init     <= 1'b0;
      lrck_q      <= 1'b0;
      in_frame    <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      cap_stb     <= 1'b0;
      cap_ch      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      cap_stb     <= 1'b0;
      frame_err_o <= 1'b0;
      if (bck_rise) begin
        if (!lr_init) begin
          lr_init <= 1'b1;
          lrck_q  <= lrck_sy[1];
        end else if (lrck_sy[1] != lrck_q) begin
          lrck_q      <= lrck_sy[1];
          frame_err_o <= in_frame;
          in_frame    <= 1'b1;
          bit_cnt     <= '0;
          cap_ch      <= lrck_sy[1];
        end else if (in_frame) begin
          if (32'(bit_cnt) < DAC_W) shreg <= {shreg[DAC_W-2:0], data_sy[1]};
          if (32'(bit_cnt) == SAMPLE_W - 1) begin
            in_frame <= 1'b0;
            cap_stb  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

  // next LFSR value and the signed difference of its low bits against the current value
  always_comb begin
    lfsr_nx = {1'b0, lfsr[15:1]};
    if (lfsr[0]) lfsr_nx = lfsr_nx ^ 16'hB400;
    d_new = {1'b0, lfsr_nx[DITHER_BITS-1:0]} - {1'b0, lfsr[DITHER_BITS-1:0]};
  end

  // conversion stage 1: truncate to DAC width and register the dither term
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lfsr <= 16'hACE1;
      s1   <= '0;
      d1   <= '0;
      st1  <= 1'b0;
      ch1  <= 1'b0;
    end else begin
      st1 <= cap_stb;
      if (cap_stb) begin
        lfsr <= lfsr_nx;
        s1   <= shreg;
        ch1  <= cap_ch;
        d1   <= (DITHER_EN != 0) ? d_new : '0;
      end
    end
  end

  // conversion stage 2: add dither, saturate, flip MSB for offset binary
  always_comb begin
    sum = {s1[DAC_W-1], s1} + {{(DAC_W-DITHER_BITS){d1[DITHER_BITS]}}, d1};
    sat = sum[DAC_W-1:0];
    if (sum[DAC_W] != sum[DAC_W-1]) sat = sum[DAC_W] ? S_MIN : S_MAX;
    code = {~sat[DAC_W-1], sat[DAC_W-2:0]};
  end

  // left has priority when both pending words wait
  always_comb begin
    ld_l = (state == S_IDLE) && vld_l;
    ld_r = (state == S_IDLE) && !vld_l && vld_r;
  end

  // SPI transmitter and per-channel pending registers; a write after a load re-arms valid
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= S_IDLE;
      sclk_o         <= 1'b0;
      sync_n_o       <= 1'b1;
      sdo_o          <= 1'b0;
      busy_o         <= 1'b0;
      overrun_o      <= 1'b0;
      sample_valid_o <= 1'b0;
      tx_sh          <= '0;
      div            <= '0;
      bitc           <= '0;
      gapc           <= '0;
      pend_l         <= MID;
      pend_r         <= MID;
      vld_l          <= 1'b1;
      vld_r          <= 1'b1;
    end else begin
      sample_valid_o <= st1;
      case (state)
        S_IDLE: begin
          if (ld_l || ld_r) begin
            tx_sh    <= ld_l ? {ADDR_L, pend_l} : {ADDR_R, pend_r};
            if (ld_l) vld_l <= 1'b0;
            else      vld_r <= 1'b0;
            sync_n_o <= 1'b0;
            busy_o   <= 1'b1;
            div      <= '0;
            bitc     <= '0;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (32'(div) + 1 >= SCLK_DIV) begin
            div <= '0;
            if (!sclk_o) begin
              sclk_o <= 1'b1;
              sdo_o  <= tx_sh[N_BITS-1];
              tx_sh  <= {tx_sh[N_BITS-2:0], 1'b0};
            end else begin
              sclk_o <= 1'b0;
              if (32'(bitc) == N_BITS - 1) begin
                sync_n_o <= 1'b1;
                gapc     <= '0;
                state    <= S_GAP;
              end else begin
                bitc <= bitc + 1'b1;
              end
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        S_GAP: begin
          if (32'(gapc) + 1 >= SYNC_GAP) begin
            busy_o <= 1'b0;
            sdo_o  <= 1'b0;
            state  <= S_IDLE;
          end else begin
            gapc <= gapc + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (st1) begin
        if (!ch1) begin
          pend_l <= code;
          vld_l  <= 1'b1;
          if (vld_l && !ld_l) overrun_o <= 1'b1;
        end else begin
          pend_r <= code;
          vld_r  <= 1'b1;
          if (vld_r && !ld_r) overrun_o <= 1'b1;
        end
      end
    end
  end

endmodule
